ofs_fim_hssi_rx_axis_bp_bridge: RTL

Parametrised successor to the plain HSSI RX connect. It adds client backpressure to the MAC RX AXI-S stream, which has no tready.
- Store-and-forward packet buffer between MAC RX and the client (PIM/AFU).
- A packet is released to the client only after its tlast is written.
- Packets that overflow the buffer are dropped whole and counted. No partial packet ever reaches the client.

---
 rtl/ofs_fim_hssi_rx_bridge_pkg.sv | 25 ++
 rtl/ofs_fim_hssi_sdp_ram.sv | 25 ++
 rtl/ofs_fim_hssi_rx_axis_bp_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_hssi_rx_bridge_pkg.sv
// Shared types and helpers for the HSSI RX store-and-forward backpressure bridge.
package ofs_fim_hssi_rx_bridge_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_USER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DROP   = 2'd2
  } wr_state_e;

  // Beat layout at default widths; the top rebuilds the same layout at its own widths
  typedef struct packed {
    logic [DEF_DATA_W-1:0]   tdata;
    logic [DEF_DATA_W/8-1:0] tkeep;
    logic                    tlast;
    logic [DEF_USER_W-1:0]   tuser;
  } hssi_beat_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofs_fim_hssi_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module ofs_fim_hssi_sdp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ofs_fim_hssi_rx_axis_bp_bridge.sv
// Store-and-forward packet buffer adding client backpressure to the MAC RX stream.
// Packets are released only once complete; packets that overflow are dropped whole.
module ofs_fim_hssi_rx_axis_bp_bridge
  import ofs_fim_hssi_rx_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned USER_W = DEF_USER_W,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_tvalid,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic [DATA_W/8-1:0]     s_tkeep,
  input  logic                    s_tlast,
  input  logic [USER_W-1:0]       s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic [DATA_W/8-1:0]     m_tkeep,
  output logic                    m_tlast,
  output logic [USER_W-1:0]       m_tuser,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    drop_pulse,
  output logic [$clog2(DEPTH):0]  fifo_used
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned AW     = PTR_W - 1;
  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  wr_state_e        r_state, w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_nxt, w_commit_ptr_nxt, w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_used;
  logic             w_full, w_we, w_commit, w_drop;
  logic             w_pop, w_rd_issue;
  logic [1:0]       w_occ;
  logic             r_rd_vld, r_head_vld, r_tail_vld;
  beat_t            r_head, r_tail, w_wr_beat, w_ram_rdata;

  // Full uses the registered read pointer, so a same-cycle read never frees room
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_used == PTR_W'(DEPTH));

  assign w_wr_beat = '{tdata: s_tdata, tkeep: s_tkeep, tlast: s_tlast, tuser: s_tuser};

  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_we             = 1'b0;
    w_commit         = 1'b0;
    w_drop           = 1'b0;
    if (s_tvalid) begin
      case (r_state)
        ST_IDLE, ST_ACCEPT: begin
          if (!w_full) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (s_tlast) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_wr_ptr + PTR_W'(1);
              w_state_nxt      = ST_IDLE;
            end else begin
              w_state_nxt = ST_ACCEPT;
            end
          end else begin
            w_drop       = 1'b1;
            w_wr_ptr_nxt = r_commit_ptr;
            w_state_nxt  = s_tlast ? ST_IDLE : ST_DROP;
          end
        end
        ST_DROP:  if (s_tlast) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Issue a RAM read only if the beat is guaranteed a skid slot when it lands
  assign w_pop        = r_head_vld & m_tready;
  assign w_occ        = 2'(r_head_vld) + 2'(r_tail_vld) + 2'(r_rd_vld) - 2'(w_pop);
  assign w_rd_issue   = (r_rd_ptr != r_commit_ptr) && (w_occ <= 2'd1);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_issue);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_rd_vld     <= 1'b0;
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
      drop_pulse   <= 1'b0;
      fifo_used    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_rd_vld     <= w_rd_issue;
      drop_pulse   <= w_drop;
      fifo_used    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      if (w_commit && (pkt_cnt != '1))  pkt_cnt  <= pkt_cnt + CNT_W'(1);
      if (w_drop && (drop_cnt != '1))   drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  ofs_fim_hssi_sdp_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wr_beat),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Two-entry skid: head drives m_*, tail absorbs the beat still in the RAM pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else begin
      case ({r_rd_vld, w_pop})
        2'b10: begin
          if (!r_head_vld) r_head_vld <= 1'b1;
          else             r_tail_vld <= 1'b1;
        end
        2'b01: begin
          r_head_vld <= r_tail_vld;
          r_tail_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case ({r_rd_vld, w_pop})
      2'b10: begin
        if (!r_head_vld) r_head <= w_ram_rdata;
        else             r_tail <= w_ram_rdata;
      end
      2'b01: r_head <= r_tail;
      2'b11: begin
        if (r_tail_vld) begin
          r_head <= r_tail;
          r_tail <= w_ram_rdata;
        end else begin
          r_head <= w_ram_rdata;
        end
      end
      default: ;
    endcase
  end

  assign m_tvalid = r_head_vld;
  assign m_tdata  = r_head.tdata;
  assign m_tkeep  = r_head.tkeep;
  assign m_tlast  = r_head.tlast;
  assign m_tuser  = r_head.tuser;

endmodule
